// File: rtl/rx_byte_fifo.sv
// ----------------------------------------------------------------------------
// rx_byte_fifo
//
// Downstream stage of the UART receiver. It watches the receiver's busy flag,
// captures the parallel byte and its parity result once per frame end, and
// buffers the entries in a DEPTH-entry circular FIFO. The host reads entries
// on a show-ahead valid/ready stream.
//
// Optional build macro:
//   RX_DROP_BAD_EN - when defined, bad-parity frames are counted but not
//                    stored, never cause overflow, and m_perr is tied to 0.
//
// Parameters:
//   DEPTH - FIFO entries (power of 2, >= 2)
//   AW    - pointer width, log2(DEPTH)
//
// Ports:
//   sys_clk      - system clock (also feeds the receiver's baud generator)
//   rst          - synchronous reset, active-high
//   rx_data      - receiver parallel byte, stable from busy fall to next load
//   rx_busy      - receiver busy, high while a frame is in progress
//   rx_parity_ok - receiver parity check, 1 = good
//   m_data       - head-of-FIFO byte (valid while m_valid)
//   m_perr       - head-of-FIFO parity error flag
//   m_valid      - head entry available
//   m_ready      - host accepts head entry
//   fill_level   - number of stored entries, 0..DEPTH
//   overflow     - sticky: a captured frame was lost to a full FIFO
//   ovf_clr      - single-cycle clear of overflow (a same-cycle set wins)
//   perr_count   - saturating count of captured bad-parity frames
// ----------------------------------------------------------------------------

module rx_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_busy,
    input  logic          rx_parity_ok,
    output logic [7:0]    m_data,
    output logic          m_perr,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   fill_level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    perr_count
);

`ifdef RX_DROP_BAD_EN
    // Only good frames are stored, so the parity flag needs no storage.
    localparam int unsigned EW = 8;
`else
    localparam int unsigned EW = 9;
`endif

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Busy synchroniser (b1, b2) plus the edge-detect stage (b3).
    logic b1_q, b2_q, b3_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    perr_count_q, perr_count_d;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    logic cap;
    logic keep;
    logic full;
    logic pop;
    logic push;
    logic ovf_set;

    always_comb begin
        // One-cycle pulse when the synchronised busy flag falls (frame end).
        // Busy held high across reset release never produces a pulse because
        // the rising edge cannot satisfy b3 & ~b2.
        cap = b3_q & ~b2_q;

`ifdef RX_DROP_BAD_EN
        keep     = rx_parity_ok;
        wr_entry = rx_data;
`else
        keep     = 1'b1;
        wr_entry = {~rx_parity_ok, rx_data};
`endif

        full    = (count_q == FULL_COUNT);
        pop     = m_valid & m_ready;
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        push    = cap & keep & (~full | pop);
        ovf_set = cap & keep & full & ~pop;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        perr_count_d = perr_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        // Counted on every bad capture, stored, dropped or filtered alike.
        if (cap && !rx_parity_ok && perr_count_q != 8'hFF) begin
            perr_count_d = perr_count_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            b1_q         <= 1'b0;
            b2_q         <= 1'b0;
            b3_q         <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            perr_count_q <= 8'd0;
        end else begin
            b1_q         <= rx_busy;
            b2_q         <= b1_q;
            b3_q         <= b2_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            perr_count_q <= perr_count_d;
        end
    end

    // Storage is not reset; entries are only visible through count_q.
    always_ff @(posedge sys_clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Show-ahead: head entry is read combinationally from rd_ptr.
    assign rd_entry = mem[rd_ptr_q];
    assign m_data   = rd_entry[7:0];

`ifdef RX_DROP_BAD_EN
    assign m_perr = 1'b0;
`else
    assign m_perr = rd_entry[8];
`endif

    assign m_valid    = (count_q != '0);
    assign fill_level = count_q;
    assign overflow   = overflow_q;
    assign perr_count = perr_count_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// ----------------------------------------------------------------------------
// tb_rx_byte_fifo
//
// Self-checking bench for rx_byte_fifo. A queue-based reference model tracks
// the stored entries, the sticky overflow flag and the parity error count;
// every clock the DUT outputs are compared against it. Directed scenarios are
// followed by a randomised frame stream.
// ----------------------------------------------------------------------------

module tb_rx_byte_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          sys_clk      = 1'b0;
    logic          rst          = 1'b1;
    logic [7:0]    rx_data      = 8'h00;
    logic          rx_busy      = 1'b0;
    logic          rx_parity_ok = 1'b1;
    logic [7:0]    m_data;
    logic          m_perr;
    logic          m_valid;
    logic          m_ready      = 1'b0;
    logic [AW:0]   fill_level;
    logic          overflow;
    logic          ovf_clr      = 1'b0;
    logic [7:0]    perr_count;

    rx_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_busy      (rx_busy),
        .rx_parity_ok (rx_parity_ok),
        .m_data       (m_data),
        .m_perr       (m_perr),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .perr_count   (perr_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: {perr, byte} entries in arrival order.
    logic [8:0] mdl_q[$];
    int         mdl_perr  = 0;
    bit         mdl_ovf   = 1'b0;
    int         ready_pct = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("fill_level", 32'(fill_level), 32'(mdl_q.size()));
        check_eq("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
        if (mdl_q.size() != 0) begin
            check_eq("m_data", 32'(m_data), 32'(mdl_q[0][7:0]));
            check_eq("m_perr", 32'(m_perr), 32'(mdl_q[0][8]));
        end
        check_eq("overflow", 32'(overflow), 32'(mdl_ovf));
        check_eq("perr_count", 32'(perr_count), 32'(mdl_perr));
    endtask

    // One clock. 'cap' tells the model that this edge is the capture edge of
    // a frame (third edge after rx_busy fell) carrying byte d / parity pok.
    task automatic tick(input bit cap, input logic [7:0] d, input bit pok);
        bit pop;
        bit full;
        bit store;
        bit ovf_set;
        pop     = (mdl_q.size() != 0) && (m_ready === 1'b1);
        full    = (mdl_q.size() == DEPTH);
        store   = cap;
`ifdef RX_DROP_BAD_EN
        store   = cap && pok;
`endif
        ovf_set = 1'b0;
        @(posedge sys_clk);
        if (cap && !pok && mdl_perr < 255) mdl_perr++;
        if (pop) void'(mdl_q.pop_front());
        if (store) begin
            if (full && !pop) ovf_set = 1'b1;
            else mdl_q.push_back({~pok, d});
        end
        if (ovf_set) mdl_ovf = 1'b1;
        else if (ovf_clr) mdl_ovf = 1'b0;
        #1;
        compare_all();
        ovf_clr = 1'b0;
        m_ready = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic frame_start();
        rx_busy = 1'b1;
        repeat (4) begin
            rx_data      = 8'($urandom);
            rx_parity_ok = 1'($urandom);
            tick(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic frame_end(input logic [7:0] d, input bit pok, input bit rdy_at_cap,
                             input bit clr_at_cap, input int gap);
        rx_data      = d;
        rx_parity_ok = pok;
        rx_busy      = 1'b0;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        if (rdy_at_cap) m_ready = 1'b1;
        if (clr_at_cap) ovf_clr = 1'b1;
        tick(1'b1, d, pok);
        repeat (gap) tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic frame(input logic [7:0] d, input bit pok, input int gap);
        frame_start();
        frame_end(d, pok, 1'b0, 1'b0, gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        mdl_q.delete();
        mdl_ovf  = 1'b0;
        mdl_perr = 0;
        m_ready  = 1'b0;
        compare_all();
    endtask

    task automatic drain();
        ready_pct = 100;
        m_ready   = 1'b1;
        repeat (DEPTH + 2) tick(1'b0, 8'h00, 1'b1);
        ready_pct = 0;
        m_ready   = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_fill", 32'(fill_level), 32'd0);

        // Single frame with explicit latency.
        ready_pct = 0;
        frame_start();
        rx_data      = 8'hA5;
        rx_parity_ok = 1'b1;
        rx_busy      = 1'b0;
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        check_eq("lat_not_yet", 32'(m_valid), 32'd0);
        tick(1'b1, 8'hA5, 1'b1);
        check_eq("lat_valid", 32'(m_valid), 32'd1);
        check_eq("single_data", 32'(m_data), 32'hA5);
        check_eq("single_perr", 32'(m_perr), 32'd0);
        check_eq("single_fill", 32'(fill_level), 32'd1);
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        check_eq("hold_data", 32'(m_data), 32'hA5);
        m_ready = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        check_eq("pop_valid", 32'(m_valid), 32'd0);
        check_eq("pop_fill", 32'(fill_level), 32'd0);

        // Ordering across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            frame(8'(i), 1'b1, 0);
            if (i % 4 == 3) begin
                m_ready = 1'b1;
                tick(1'b0, 8'h00, 1'b1);
            end
        end
        check_eq("wrap_fill", 32'(fill_level), 32'd15);
        check_eq("wrap_no_ovf", 32'(overflow), 32'd0);
        drain();

        // Full / overflow, then clear.
        for (int i = 0; i < 17; i++) frame(8'h40 + 8'(i), 1'b1, 0);
        check_eq("full_fill", 32'(fill_level), 32'd16);
        check_eq("full_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1'b0, 8'h00, 1'b1);
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        drain();

        // Full with capture and pop in the same cycle; then set-vs-clear.
        for (int i = 0; i < 16; i++) frame(8'h80 + 8'(i), 1'b1, 0);
        frame_start();
        frame_end(8'hEE, 1'b1, 1'b1, 1'b0, 0);
        check_eq("fullpop_fill", 32'(fill_level), 32'd16);
        check_eq("fullpop_ovf", 32'(overflow), 32'd0);
        frame_start();
        frame_end(8'hEF, 1'b1, 1'b0, 1'b1, 0);
        check_eq("set_wins", 32'(overflow), 32'd1);
        ready_pct = 100;
        m_ready   = 1'b1;
        repeat (15) tick(1'b0, 8'h00, 1'b1);
        check_eq("last_entry", 32'(m_data), 32'hEE);
        drain();
        ovf_clr = 1'b1;
        tick(1'b0, 8'h00, 1'b1);

        // Parity errors and saturation.
        do_reset();
        for (int i = 0; i < 3; i++) frame(8'h3C, 1'b0, 0);
        check_eq("perr_3", 32'(perr_count), 32'd3);
`ifdef RX_DROP_BAD_EN
        check_eq("perr_fill", 32'(fill_level), 32'd0);
`else
        check_eq("perr_fill", 32'(fill_level), 32'd3);
        check_eq("perr_flag", 32'(m_perr), 32'd1);
`endif
        ready_pct = 50;
        for (int i = 0; i < 300; i++) frame(8'($urandom), 1'b0, 0);
        check_eq("perr_sat", 32'(perr_count), 32'd255);
        drain();

        // Reset mid-operation, busy high across reset release.
        do_reset();
        frame(8'h11, 1'b0, 0);
        for (int i = 0; i < 17; i++) frame(8'h20 + 8'(i), 1'b1, 0);
        m_ready   = 1'b1;
        ready_pct = 100;
        repeat (11) tick(1'b0, 8'h00, 1'b1);
        ready_pct = 0;
        m_ready   = 1'b0;
        check_eq("pre_rst_fill", 32'(fill_level), 32'd5);
        check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
        rx_busy = 1'b1;
        do_reset();
        check_eq("mid_rst_fill", 32'(fill_level), 32'd0);
        check_eq("mid_rst_valid", 32'(m_valid), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        check_eq("mid_rst_perr", 32'(perr_count), 32'd0);
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        frame_end(8'h5A, 1'b1, 1'b0, 1'b0, 1);
        check_eq("post_rst_data", 32'(m_data), 32'h5A);
        drain();

        // Randomised frame stream.
        for (int i = 0; i < 150; i++) begin
            ready_pct = int'($urandom_range(100));
            frame_start();
            frame_end(8'($urandom), ($urandom_range(3) != 0), 1'($urandom),
                      ($urandom_range(7) == 0), int'($urandom_range(3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
